instr_mem_responder: RTL
========================

# instr_mem_responder

Instruction-memory responder on the fetch side of the CPU: accepts word addresses from the program counter over a valid/ready request channel, reads a synchronous word-organised instruction store and returns the instruction on a valid/ready response channel. A loader write port fills the store before or between runs. It sits between the program counter and the decode stage and supports one fetch per cycle under backpressure.

## Interface
- DEPTH_WORDS, 256: instruction words stored (power of two, 16..4096)
- AW, clog2(DEPTH_WORDS): loader word-index width (derived, not overridden)
- clka  in  1  clock, all state on rising edge
- rsta  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  32  byte address from the program counter
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response this cycle
- rsp_data  out  32  instruction word
- rsp_addr  out  32  byte address the response belongs to
- rsp_err  out  1  address misaligned or out of range
- ld_en  in  1  loader write strobe
- ld_addr  in  AW  loader word index
- ld_data  in  32  loader write data

## Operation
- Store: DEPTH_WORDS x 32, synchronous read, one write port (loader). Contents not reset.
- Accept: fire = req_valid && req_ready. On fire, word index req_addr[AW+1:2] read issued; req_addr and error flag captured into an in-flight register (inflight=1).
- Error: rsp_err=1 if req_addr[1:0]!=0 or req_addr[31:AW+2]!=0; then rsp_data=32'h0000_0000 (NOP), store not read.
- Next cycle the in-flight entry {data, addr, err} pushes into a 2-entry response FIFO; head drives rsp_*.
- Pop = rsp_valid && rsp_ready. Push and pop in same cycle allowed; occupancy unchanged.
- Credit: req_ready = !ld_en && (count + inflight - pop) < 2, count = FIFO occupancy 0..2. FIFO never overflows.
- Loader: ld_en=1 writes ld_data to ld_addr at the edge; forces req_ready=0 that cycle, so loads and fetch reads never share a cycle. Response draining continues during loads.
- Responses returned strictly in request order.

## Timing
- Reset (rsta=0): rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, inflight=0, count=0; in-flight and queued responses discarded. req_ready follows its equation once rsta=1 (1 when ld_en=0).
- Latency: request fired at edge N -> rsp_valid=1 after edge N+1 if FIFO was empty or popped.
- Throughput: 1 response/cycle with rsp_ready held 1 and req_valid held 1.
- Backpressure: rsp_ready=0 -> at most 2 outstanding (FIFO full, or 1 queued + 1 in flight); req_ready drops to 0 until a pop.
- rsp_data/rsp_addr/rsp_err stable while rsp_valid=1 and rsp_ready=0.
- ld_en and req_valid same cycle: load wins, request not accepted, requester retries.
- Write to word W then fetch of W accepted next cycle returns new data.
- Reset mid-stream: rsta asserted asynchronously clears state immediately; first response after release belongs to the first request accepted after release.

## Structure
- Shared package imem_pkg: DEPTH_WORDS default, NOP word constant 32'h0000_0000, response struct {data[31:0], addr[31:0], err}.
- Sub-module resp_fifo2: 2-entry FIFO of the response struct with push, pop, count, head outputs; async active-low reset on rsta.

## Test plan
- Load words 0..3 = 32'h1111_0000+i, fetch addresses 0,4,8,12 back-to-back with rsp_ready=1 -> four responses on consecutive cycles, data 32'h1111_0000..3, first rsp_valid one cycle after first fire.
- Same stream with rsp_ready=0 for 5 cycles -> req_ready=0 after 2 accepts, rsp holds addr 0 data stable; release -> remaining responses in order, none lost or duplicated.
- Fetch req_addr=32'h0000_0006 and 32'h0000_0400 (DEPTH 256) -> rsp_err=1, rsp_data=0, rsp_addr echoes request.
- ld_en=1 with req_valid=1 same cycle -> req_ready=0, write lands; next-cycle fetch of that word returns ld_data.
- Assert rsta with 2 responses outstanding -> rsp_valid=0 immediately; after release, fetch addr 0 -> single response for addr 0 only.
- Random req_valid/rsp_ready/ld_en over 10k cycles against reference queue model -> in-order match, count never exceeds 2.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
  localparam int          DEPTH_WORDS_DEF = 256;
  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } rsp_t;
endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO; entry 0 is always the head so outputs stay put
// until a pop.
module resp_fifo2
  import imem_pkg::*;
(
  input  logic       clka,
  input  logic       rsta,
  input  logic       push,
  input  logic       pop,
  input  rsp_t       din,
  output rsp_t       head,
  output logic [1:0] count
);
  rsp_t ent0, ent1;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; shift only when the second slot is live
          if (count == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;
endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side instruction store: valid/ready word fetches from the PC,
// in-order responses through a 2-deep credit-managed FIFO, loader write port.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter  int DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_data;
  logic        inflight;
  logic [31:0] if_addr;
  logic        if_err;
  logic        req_err, fire, pop;
  logic [1:0]  count;
  logic [2:0]  occ;
  rsp_t        push_ent, head;

  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign fire    = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;

  // Slots committed next cycle: queued + in flight, minus what leaves now.
  assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign req_ready = !ld_en && (occ < 3'd2);

  always_ff @(posedge clka) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (fire && !req_err) rd_data <= mem[req_addr[AW+1:2]];
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      inflight <= 1'b0;
      if_addr  <= '0;
      if_err   <= 1'b0;
    end else begin
      inflight <= fire;
      if (fire) begin
        if_addr <= req_addr;
        if_err  <= req_err;
      end
    end
  end

  assign push_ent = '{data: (if_err ? NOP_WORD : rd_data), addr: if_addr, err: if_err};

  resp_fifo2 u_fifo (
    .clka  (clka),
    .rsta  (rsta),
    .push  (inflight),
    .pop   (pop),
    .din   (push_ent),
    .head  (head),
    .count (count)
  );

  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = head.data;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;
endmodule
